// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the E/I RAM port arbiter.
// Owner encoding, read-latency bounds and the tie-break rule.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_E    = 2'd1,
        OWN_I    = 2'd2
    } owner_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // On a tie the requester that did not own last wins.
    function automatic owner_t pick(
        input logic e,
        input logic i,
        input logic last_i
    );
        owner_t w;
        unique case ({e, i})
            2'b11:   w = last_i ? OWN_E : OWN_I;
            2'b10:   w = OWN_E;
            2'b01:   w = OWN_I;
            default: w = OWN_NONE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_tag_pipe.sv
// Read-valid tag shift register: {valid, id} per stage.
// Returns the read-valid strobe to the requester that issued it.
module arb_tag_pipe
    import ram_port_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    input  logic i_id,
    output logic o_e_valid,
    output logic o_i_valid
);

    localparam int DEPTH =
        (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
        (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX :
        RD_LATENCY;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_id;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_id    <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_id[0]    <= i_valid & i_id;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_id[k]    <= r_id[k-1];
            end
        end
    end

    assign o_e_valid = r_valid[DEPTH-1] & ~r_id[DEPTH-1];
    assign o_i_valid = r_valid[DEPTH-1] &  r_id[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin owner of the shared dual-read/single-write RAM
// between the Euler core (E) and the Interpolation unit (I).
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 13,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     E_REQ,
    input  logic                     E_LOCK,
    input  logic                     E_WE,
    input  logic [ADDRESS_WIDTH-1:0] E_ADD_RD1,
    input  logic [ADDRESS_WIDTH-1:0] E_ADD_RD2,
    input  logic [ADDRESS_WIDTH-1:0] E_ADD_WR,
    input  logic [DATA_WIDTH-1:0]    E_DATA_WR,
    output logic                     E_GNT,
    output logic                     E_RVALID,
    input  logic                     I_REQ,
    input  logic                     I_LOCK,
    input  logic                     I_WE,
    input  logic [ADDRESS_WIDTH-1:0] I_ADD_RD1,
    input  logic [ADDRESS_WIDTH-1:0] I_ADD_RD2,
    input  logic [ADDRESS_WIDTH-1:0] I_ADD_WR,
    input  logic [DATA_WIDTH-1:0]    I_DATA_WR,
    output logic                     I_GNT,
    output logic                     I_RVALID,
    output logic [DATA_WIDTH-1:0]    DATA_RD1,
    output logic [DATA_WIDTH-1:0]    DATA_RD2,
    output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD1,
    output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD2,
    output logic [ADDRESS_WIDTH-1:0] RAM_ADD_WR,
    output logic [DATA_WIDTH-1:0]    RAM_DATA_WR,
    output logic                     RAM_ENABLE_WR,
    input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD1,
    input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD2
);

    owner_t r_owner;
    logic   r_last_i;

    logic w_e_own;
    logic w_i_own;
    logic w_e_xfer;
    logic w_i_xfer;

    assign w_e_own  = (r_owner == OWN_E);
    assign w_i_own  = (r_owner == OWN_I);
    assign w_e_xfer = w_e_own & E_REQ;
    assign w_i_xfer = w_i_own & I_REQ;

    // A releasing owner hands over only to the other side;
    // it must re-request to win again, so LOCK is the only hold.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_owner  <= OWN_NONE;
            r_last_i <= 1'b1;
        end else begin
            unique case (r_owner)
                OWN_E: begin
                    if (!(E_REQ && E_LOCK)) begin
                        r_owner  <= I_REQ ? OWN_I : OWN_NONE;
                        r_last_i <= 1'b0;
                    end
                end
                OWN_I: begin
                    if (!(I_REQ && I_LOCK)) begin
                        r_owner  <= E_REQ ? OWN_E : OWN_NONE;
                        r_last_i <= 1'b1;
                    end
                end
                default: r_owner <= pick(E_REQ, I_REQ, r_last_i);
            endcase
        end
    end

    assign E_GNT = w_e_own;
    assign I_GNT = w_i_own;

    always_comb begin
        RAM_ADD_RD1   = '0;
        RAM_ADD_RD2   = '0;
        RAM_ADD_WR    = '0;
        RAM_DATA_WR   = '0;
        RAM_ENABLE_WR = 1'b0;
        unique case (1'b1)
            w_e_own: begin
                RAM_ADD_RD1   = E_ADD_RD1;
                RAM_ADD_RD2   = E_ADD_RD2;
                RAM_ADD_WR    = E_ADD_WR;
                RAM_DATA_WR   = E_DATA_WR;
                RAM_ENABLE_WR = w_e_xfer & E_WE;
            end
            w_i_own: begin
                RAM_ADD_RD1   = I_ADD_RD1;
                RAM_ADD_RD2   = I_ADD_RD2;
                RAM_ADD_WR    = I_ADD_WR;
                RAM_DATA_WR   = I_DATA_WR;
                RAM_ENABLE_WR = w_i_xfer & I_WE;
            end
            default: ;
        endcase
    end

    arb_tag_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_tag_pipe (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_valid  (w_e_xfer | w_i_xfer),
        .i_id     (w_i_xfer),
        .o_e_valid(E_RVALID),
        .o_i_valid(I_RVALID)
    );

    assign DATA_RD1 = RAM_DATA_RD1;
    assign DATA_RD2 = RAM_DATA_RD2;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: three arbiters (RD_LATENCY 1..3) share stimulus,
// a tag scoreboard predicts RVALID and returned read data.
module tb_ram_port_arbiter;

    logic CLK;
    logic RST;

    logic        e_req, e_lock, e_we;
    logic [12:0] e_a1, e_a2, e_aw;
    logic [63:0] e_dw;
    logic        i_req, i_lock, i_we;
    logic [12:0] i_a1, i_a2, i_aw;
    logic [63:0] i_dw;

    logic [2:0]       eg, ig, erv, irv, we;
    logic [2:0][12:0] ra1, ra2, raw;
    logic [2:0][63:0] rdw, d1, d2, rd1, rd2;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        int          due;
        logic        is_i;
        logic [12:0] a1;
        logic [12:0] a2;
    } tag_t;

    tag_t q0[$];
    tag_t q1[$];
    tag_t q2[$];

    function automatic logic [63:0] fdat(input logic [12:0] a);
        return {a, a, a, a, 12'hABC};
    endfunction

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar k = 0; k < 3; k++) begin : g
        logic [12:0] p1 [k+1];
        logic [12:0] p2 [k+1];

        always @(posedge CLK) begin
            p1[0] <= ra1[k];
            p2[0] <= ra2[k];
            for (int j = 1; j <= k; j++) begin
                p1[j] <= p1[j-1];
                p2[j] <= p2[j-1];
            end
        end

        assign rd1[k] = fdat(p1[k]);
        assign rd2[k] = ~fdat(p2[k]);

        ram_port_arbiter #(
            .DATA_WIDTH(64),
            .ADDRESS_WIDTH(13),
            .RD_LATENCY(k + 1)
        ) u_dut (
            .CLK(CLK), .RST(RST),
            .E_REQ(e_req), .E_LOCK(e_lock), .E_WE(e_we),
            .E_ADD_RD1(e_a1), .E_ADD_RD2(e_a2),
            .E_ADD_WR(e_aw), .E_DATA_WR(e_dw),
            .E_GNT(eg[k]), .E_RVALID(erv[k]),
            .I_REQ(i_req), .I_LOCK(i_lock), .I_WE(i_we),
            .I_ADD_RD1(i_a1), .I_ADD_RD2(i_a2),
            .I_ADD_WR(i_aw), .I_DATA_WR(i_dw),
            .I_GNT(ig[k]), .I_RVALID(irv[k]),
            .DATA_RD1(d1[k]), .DATA_RD2(d2[k]),
            .RAM_ADD_RD1(ra1[k]), .RAM_ADD_RD2(ra2[k]),
            .RAM_ADD_WR(raw[k]), .RAM_DATA_WR(rdw[k]),
            .RAM_ENABLE_WR(we[k]),
            .RAM_DATA_RD1(rd1[k]), .RAM_DATA_RD2(rd2[k])
        );
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input logic is_i,
                        input logic [12:0] a1,
                        input logic [12:0] a2);
        tag_t t;
        t.is_i = is_i;
        t.a1   = a1;
        t.a2   = a2;
        t.due  = cyc + 1;
        q0.push_back(t);
        t.due  = cyc + 2;
        q1.push_back(t);
        t.due  = cyc + 3;
        q2.push_back(t);
    endtask

    task automatic chk_rv(input int k);
        tag_t t;
        logic hit;
        t   = '{default: 0};
        hit = 1'b0;
        case (k)
            0: if (q0.size() > 0 && q0[0].due == cyc) begin
                t = q0.pop_front(); hit = 1'b1;
            end
            1: if (q1.size() > 0 && q1[0].due == cyc) begin
                t = q1.pop_front(); hit = 1'b1;
            end
            default: if (q2.size() > 0 && q2[0].due == cyc) begin
                t = q2.pop_front(); hit = 1'b1;
            end
        endcase
        chk($sformatf("E_RVALID_L%0d", k + 1), erv[k], hit && !t.is_i);
        chk($sformatf("I_RVALID_L%0d", k + 1), irv[k], hit && t.is_i);
        if (hit) begin
            chk($sformatf("DATA_RD1_L%0d", k + 1), d1[k], fdat(t.a1));
            chk($sformatf("DATA_RD2_L%0d", k + 1), d2[k], ~fdat(t.a2));
        end
    endtask

    // One clock cycle: check at negedge, then advance past posedge.
    task automatic step(input logic xeg, input logic xig);
        logic        xe, xi, xwe;
        logic [12:0] x1, x2, xw;
        logic [63:0] xd;
        @(negedge CLK);
        xe  = xeg && e_req;
        xi  = xig && i_req;
        xwe = (xe && e_we) || (xi && i_we);
        x1  = xeg ? e_a1 : (xig ? i_a1 : 13'h0);
        x2  = xeg ? e_a2 : (xig ? i_a2 : 13'h0);
        xw  = xeg ? e_aw : (xig ? i_aw : 13'h0);
        xd  = xeg ? e_dw : (xig ? i_dw : 64'h0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("E_GNT_L%0d", k + 1), eg[k], xeg);
            chk($sformatf("I_GNT_L%0d", k + 1), ig[k], xig);
            chk($sformatf("RAM_ENABLE_WR_L%0d", k + 1), we[k], xwe);
            chk($sformatf("RAM_ADD_RD1_L%0d", k + 1), ra1[k], x1);
            chk($sformatf("RAM_ADD_RD2_L%0d", k + 1), ra2[k], x2);
            chk($sformatf("RAM_ADD_WR_L%0d", k + 1), raw[k], xw);
            chk($sformatf("RAM_DATA_WR_L%0d", k + 1), rdw[k], xd);
            chk_rv(k);
        end
        if (xe) push(1'b0, e_a1, e_a2);
        if (xi) push(1'b1, i_a1, i_a2);
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        e_req = 0; e_lock = 0; e_we = 0;
        e_a1 = '0; e_a2 = '0; e_aw = '0; e_dw = '0;
        i_req = 0; i_lock = 0; i_we = 0;
        i_a1 = '0; i_a2 = '0; i_aw = '0; i_dw = '0;
        RST = 1'b1;
        #1 RST = 1'b0;

        // reset held, then 10 idle cycles
        repeat (3) step(0, 0);
        RST = 1'b1;
        repeat (10) step(0, 0);

        // both requesting, no lock: E,I,E,I,... starting with E
        e_req = 1; i_req = 1;
        step(0, 0);
        for (int n = 0; n < 6; n++) begin
            e_a1 = 13'h010 + 13'(n);
            e_a2 = 13'h020 + 13'(n);
            i_a1 = 13'h200 + 13'(n);
            i_a2 = 13'h300 + 13'(n);
            if (n % 2 == 0) step(1, 0);
            else step(0, 1);
        end
        e_req = 0; i_req = 0;
        step(1, 0);
        step(0, 0);

        // single E write, grant lasts one transfer
        e_req = 1; e_we = 1;
        e_aw = 13'h0A5; e_dw = 64'hDEAD;
        step(0, 0);
        step(1, 0);
        e_req = 0; e_we = 0;
        step(0, 0);
        step(0, 0);

        // E locks for 4 transfers while I waits
        e_req = 1; e_lock = 1;
        e_a1 = 13'h040; e_a2 = 13'h041;
        step(0, 0);
        i_req = 1;
        repeat (4) step(1, 0);
        e_lock = 0;
        step(1, 0);
        e_req = 0;
        step(0, 1);
        i_req = 0;
        step(0, 0);

        // I reads 0x100/0x101, E granted right after
        i_req = 1; i_a1 = 13'h100; i_a2 = 13'h101;
        step(0, 0);
        e_req = 1; e_lock = 1;
        e_a1 = 13'h050; e_a2 = 13'h051;
        step(0, 1);
        i_req = 0;
        step(1, 0);
        e_lock = 0;
        step(1, 0);
        e_req = 0;
        repeat (4) step(0, 0);

        // reset mid-lock with reads in flight
        e_req = 1; e_lock = 1;
        e_a1 = 13'h060; e_a2 = 13'h061;
        step(0, 0);
        step(1, 0);
        step(1, 0);
        #1 RST = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("RST_E_GNT_L%0d", k + 1), eg[k], 1'b0);
            chk($sformatf("RST_I_GNT_L%0d", k + 1), ig[k], 1'b0);
            chk($sformatf("RST_E_RVALID_L%0d", k + 1), erv[k], 1'b0);
            chk($sformatf("RST_I_RVALID_L%0d", k + 1), irv[k], 1'b0);
            chk($sformatf("RST_WE_L%0d", k + 1), we[k], 1'b0);
        end
        q0.delete();
        q1.delete();
        q2.delete();
        e_lock = 0; i_req = 1;
        i_a1 = 13'h070; i_a2 = 13'h071;
        repeat (3) step(0, 0);
        RST = 1'b1;
        step(0, 0);
        step(1, 0);
        e_req = 0;
        step(0, 1);
        i_req = 0;
        repeat (4) step(0, 0);

        chk("SB_DRAINED", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
